// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key expansion slice.
package aes_pkg;

  localparam int NUM_ROUNDS  = 10;
  localparam int KEY_W       = 128;
  localparam int ROUND_IDX_W = 4;
  localparam int NUM_KEYS    = NUM_ROUNDS + 1;

  // Index of the final round key; also the highest legal buffer index.
  localparam logic [ROUND_IDX_W-1:0] LAST_ROUND = ROUND_IDX_W'(NUM_ROUNDS);

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  // Forward AES S-box, indexed by the input byte.
  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/g_function.sv
// AES key-schedule word transform: RotWord, SubWord, then XOR of the round constant.
module g_function
  import aes_pkg::*;
(
  input  word_t                  word_in,
  input  logic [ROUND_IDX_W-1:0] round,
  output word_t                  word_out
);

  word_t      rot_word;
  word_t      sub_word;
  logic [7:0] rcon;

  assign rot_word = {word_in[23:0], word_in[31:24]};
  assign sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                     sbox(rot_word[15:8]),  sbox(rot_word[7:0])};

  // Round constant lookup; rounds outside 1..10 contribute nothing.
  always_comb begin
    // NOTE: every path assigns rcon (the default arm included), so no latch can be inferred.
    unique case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign word_out = sub_word ^ {rcon, 24'h0};

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion: one round key per clock into an 11-entry buffer,
// streamed as produced and readable at random with one cycle of latency.
module aes_key_schedule
  import aes_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KEY_W-1:0]       key_in,
  output logic                   busy,
  output logic                   keys_ready,
  output logic                   rk_valid,
  output logic [ROUND_IDX_W-1:0] rk_idx,
  output logic [KEY_W-1:0]       rk_data,
  input  logic [ROUND_IDX_W-1:0] rd_idx,
  output logic [KEY_W-1:0]       rd_key
);

  ks_state_e              state_q;
  ks_state_e              state_d;
  logic                   load;
  logic                   step;
  logic [ROUND_IDX_W-1:0] round_cnt;
  logic [ROUND_IDX_W-1:0] g_round;
  logic [KEY_W-1:0]       work_key;
  logic [KEY_W-1:0]       next_key;
  logic [KEY_W-1:0]       key_buf [NUM_KEYS];
  word_t                  g_out;
  word_t                  nw0;
  word_t                  nw1;
  word_t                  nw2;
  word_t                  nw3;

  // Hold the constant's round at 1 outside EXPAND so it never sees an undecoded value.
  assign g_round = (state_q == EXPAND) ? round_cnt : ROUND_IDX_W'(1);

  g_function u_g_function (
    .word_in  (work_key[31:0]),
    .round    (g_round),
    .word_out (g_out)
  );

  // Each new word chains off the one just produced; all plain XOR.
  assign nw0      = work_key[127:96] ^ g_out;
  assign nw1      = work_key[95:64]  ^ nw0;
  assign nw2      = work_key[63:32]  ^ nw1;
  assign nw3      = work_key[31:0]   ^ nw2;
  assign next_key = {nw0, nw1, nw2, nw3};

  assign busy       = (state_q == EXPAND);
  assign keys_ready = (state_q == READY);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register updates from pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept start only when idle or finished; leave EXPAND after the last round.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        if (start) begin
          load    = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (round_cnt == LAST_ROUND) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working key, round counter, key buffer and streamed output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_cnt <= '0;
      work_key  <= '0;
      rk_valid  <= 1'b0;
      rk_idx    <= '0;
      rk_data   <= '0;
      // NOTE: the key buffer is cleared on reset so no stale key survives it; that is why it lives in flops.
      for (int i = 0; i < NUM_KEYS; i++) key_buf[i] <= '0;
    end else begin
      rk_valid <= 1'b0;
      if (load) begin
        key_buf[0] <= key_in;
        work_key   <= key_in;
        round_cnt  <= ROUND_IDX_W'(1);
        rk_valid   <= 1'b1;
        rk_idx     <= '0;
        rk_data    <= key_in;
      end else if (step) begin
        key_buf[round_cnt] <= next_key;
        work_key           <= next_key;
        rk_valid           <= 1'b1;
        rk_idx             <= round_cnt;
        rk_data            <= next_key;
        if (round_cnt != LAST_ROUND) round_cnt <= round_cnt + ROUND_IDX_W'(1);
      end
    end
  end

  // Registered buffer read; out-of-range indices read as zero, same-edge writes are not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rd_key <= '0;
    else if (rd_idx <= LAST_ROUND) rd_key <= key_buf[rd_idx];
    else                           rd_key <= '0;
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a FIPS-197 style expansion model.
module tb_aes_key_schedule;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         keys_ready;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] exp_keys [11];
  logic [127:0] got_keys [11];

  aes_key_schedule dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .keys_ready (keys_ready),
    .rk_valid   (rk_valid),
    .rk_idx     (rk_idx),
    .rk_data    (rk_data),
    .rd_idx     (rd_idx),
    .rd_key     (rd_key)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (GF(2^8) arithmetic, FIPS-197 word recurrence) ----------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  task automatic init_model();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gf_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- generic expansion run ------------------------------------------------------
  // Start on edge T, then watch T..T+12. start is kept high for `hold` edges and additionally
  // pulsed on edge T+pulse_at (0 = no extra pulse) with random junk on key_in.
  task automatic expand_and_check(input logic [127:0] key, input int hold, input int pulse_at,
                                  input string tag);
    int n_pulses = 0;
    model_expand(key);
    @(negedge clk);
    start  = 1'b1;
    key_in = key;
    @(posedge clk);
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (rk_valid) n_pulses++;
      if (i <= 10) begin
        got_keys[i] = rk_data;
        n_checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk_data !== exp_keys[i]) begin
          n_fail++;
          $display("FAIL %s stream[%0d]: got valid=%b idx=%0d data=%h, want valid=1 idx=%0d data=%h",
                   tag, i, rk_valid, rk_idx, rk_data, i, exp_keys[i]);
        end
        n_checks++;
        if (busy !== (i < 10) || keys_ready !== (i == 10)) begin
          n_fail++;
          $display("FAIL %s status[%0d]: got busy=%b keys_ready=%b, want busy=%b keys_ready=%b",
                   tag, i, busy, keys_ready, i < 10, i == 10);
        end
      end else begin
        n_checks++;
        if (rk_valid !== 1'b0 || rk_idx !== 4'd10 || rk_data !== exp_keys[10] ||
            busy !== 1'b0 || keys_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s idle[%0d]: got valid=%b idx=%0d data=%h busy=%b rdy=%b, want 0/10/%h/0/1",
                   tag, i, rk_valid, rk_idx, rk_data, busy, keys_ready, exp_keys[10]);
        end
      end
      start  = (i < hold - 1) || (pulse_at > 0 && i == pulse_at - 1);
      key_in = rand_key();
    end
    start = 1'b0;
    n_checks++;
    if (n_pulses != 11) begin
      n_fail++;
      $display("FAIL %s pulse_count: got %0d, want 11", tag, n_pulses);
    end
  endtask

  task automatic readback_sweep(input string tag);
    logic [127:0] want;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_idx = 4'(i);
      @(negedge clk);
      want = (i <= 10) ? exp_keys[i] : 128'h0;
      n_checks++;
      if (rd_key !== want) begin
        n_fail++;
        $display("FAIL %s read[%0d]: got %h, want %h", tag, i, rd_key, want);
      end
    end
  endtask

  // ---------------- scenarios ------------------------------------------------------------------
  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    key_in = '0;
    rd_idx = '0;
    #3;
    n_checks++;
    if (busy !== 1'b0 || keys_ready !== 1'b0 || rk_valid !== 1'b0 || rk_idx !== 4'd0 ||
        rk_data !== 128'h0 || rd_key !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b rdy=%b valid=%b idx=%0d data=%h rd=%h, want all 0",
               busy, keys_ready, rk_valid, rk_idx, rk_data, rd_key);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips(input string tag);
    expand_and_check(FIPS_KEY, 1, 0, tag);
    n_checks++;
    if (got_keys[1] !== FIPS_RK1 || got_keys[10] !== FIPS_RK10) begin
      n_fail++;
      $display("FAIL %s vectors: got rk1=%h rk10=%h, want %h %h",
               tag, got_keys[1], got_keys[10], FIPS_RK1, FIPS_RK10);
    end
  endtask

  task automatic test_zero_key();
    expand_and_check(128'h0, 1, 0, "zero");
    n_checks++;
    if (got_keys[1] !== ZERO_RK1 || got_keys[10] !== ZERO_RK10) begin
      n_fail++;
      $display("FAIL zero vectors: got rk1=%h rk10=%h, want %h %h",
               got_keys[1], got_keys[10], ZERO_RK1, ZERO_RK10);
    end
    readback_sweep("zero");
  endtask

  task automatic test_start_during_expand();
    expand_and_check(FIPS_KEY, 1, 4, "ignore_start");
    n_checks++;
    if (got_keys[10] !== FIPS_RK10) begin
      n_fail++;
      $display("FAIL ignore_start final: got %h, want %h", got_keys[10], FIPS_RK10);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start  = 1'b1;
    key_in = FIPS_KEY;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    rd_idx = 4'd0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || keys_ready !== 1'b0 || rk_valid !== 1'b0 || rd_key !== 128'h0) begin
      n_fail++;
      $display("FAIL mid_reset async: got busy=%b rdy=%b valid=%b rd=%h, want all 0",
               busy, keys_ready, rk_valid, rd_key);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    rd_idx = 4'd0;
    @(negedge clk);
    n_checks++;
    if (rd_key !== 128'h0 || busy !== 1'b0 || keys_ready !== 1'b0 || rk_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset after_release: got rd=%h busy=%b rdy=%b valid=%b, want 0/0/0/0",
               rd_key, busy, keys_ready, rk_valid);
    end
    test_fips("fips_after_reset");
  endtask

  task automatic test_restart_from_ready();
    logic [127:0] old_k10;
    logic [127:0] want;
    model_expand(FIPS_KEY);
    old_k10 = exp_keys[10];
    model_expand(128'h0);
    @(negedge clk);
    rd_idx = 4'd10;
    start  = 1'b1;
    key_in = 128'h0;
    @(posedge clk);
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk);
      start = 1'b0;
      want  = (i <= 10) ? old_k10 : exp_keys[10];
      n_checks++;
      if (keys_ready !== (i >= 10) || rd_key !== want) begin
        n_fail++;
        $display("FAIL restart[%0d]: got rdy=%b rd10=%h, want rdy=%b rd10=%h",
                 i, keys_ready, rd_key, i >= 10, want);
      end
    end
  endtask

  task automatic test_back_to_back_hold();
    expand_and_check(rand_key(), 3, 0, "held_start");
  endtask

  task automatic test_random_keys();
    for (int n = 0; n < 3; n++) begin
      expand_and_check(rand_key(), 1, 0, "random");
      readback_sweep("random");
      for (int j = 0; j < 6; j++) begin
        logic [3:0]   idx = 4'($urandom_range(0, 15));
        logic [127:0] want;
        @(negedge clk);
        rd_idx = idx;
        @(negedge clk);
        want = (idx <= 4'd10) ? exp_keys[idx] : 128'h0;
        n_checks++;
        if (rd_key !== want) begin
          n_fail++;
          $display("FAIL random_read[%0d]: got %h, want %h", idx, rd_key, want);
        end
      end
    end
  endtask

  initial begin
    init_model();
    test_reset();
    test_fips("fips");
    test_zero_key();
    test_fips("fips_reload");
    test_start_during_expand();
    test_reset_mid();
    test_restart_from_ready();
    test_back_to_back_hold();
    test_random_keys();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
